// File: rtl/ibuf_fetch_ctrl.sv
// Instruction fetch controller: sequences fetch PCs into the icache and emits per-slot valid masks toward the instruction buffer.
// Latency: fetch_req_o/inst_vld_o are combinational from state and inputs; PC and state update on the next rising edge.
// Backpressure: ibuf_full_i drops fetch_req_o at once and parks in HOLD; optional stall counter under FETCH_CTRL_STATS_EN.
module ibuf_fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        flush_rt_i,
  input  logic [63:0] redirect_pc_i,
  input  logic        ibuf_full_i,
  input  logic        ic_ack_i,
  input  logic        ic_miss_i,
  input  logic        ic_fill_i,
  output logic        fetch_req_o,
  output logic [63:0] fetch_pc_o,
  output logic [7:0]  inst_vld_o
`ifdef FETCH_CTRL_STATS_EN
  ,
  output logic [31:0] stall_cnt_o
`endif
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    HOLD      = 3'd2,
    WAIT_MISS = 3'd3,
    REDIRECT  = 3'd4
  } state_t;

  // Instructions are 4-byte aligned; the low two PC bits are always cleared.
  localparam logic [63:0] PC_ALIGN = 64'hFFFF_FFFF_FFFF_FFFC;

  state_t      state;
  state_t      state_nxt;
  logic [63:0] pc;
  logic [63:0] pc_nxt;
  logic [7:0]  slot_mask;
  logic        ack_take;

  assign fetch_pc_o = pc;

  // State and fetch PC registers; reset parks in IDLE at the aligned reset vector.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      pc    <= RESET_PC & PC_ALIGN;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // Slots at or after the entry offset within the 32-byte line are valid.
  always_comb begin
    slot_mask = 8'h00;
    for (int k = 0; k < 8; k++) begin
      slot_mask[k] = (3'(k) >= pc[4:2]);
    end
  end

  // Request/valid outputs and next-state/PC selection; flush overrides everything.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    fetch_req_o = 1'b0;
    inst_vld_o  = 8'h00;

    if (state == FETCH) begin
      fetch_req_o = !ibuf_full_i;
    end

    // A miss or a flush in the same cycle discards the returned line.
    ack_take = fetch_req_o && ic_ack_i && !ic_miss_i && !flush_rt_i;
    if (ack_take) begin
      inst_vld_o = slot_mask;
    end

    if (flush_rt_i) begin
      pc_nxt    = redirect_pc_i & PC_ALIGN;
      state_nxt = REDIRECT;
    end else begin
      case (state)
        IDLE: state_nxt = FETCH;
        FETCH: begin
          if (ibuf_full_i) begin
            state_nxt = HOLD;
          end else if (ic_miss_i) begin
            state_nxt = WAIT_MISS;
          end else if (ic_ack_i) begin
            pc_nxt = {pc[63:5] + 59'd1, 5'b0_0000};
          end
        end
        HOLD: begin
          if (!ibuf_full_i) begin
            state_nxt = FETCH;
          end
        end
        WAIT_MISS: begin
          if (ic_fill_i) begin
            state_nxt = FETCH;
          end
        end
        REDIRECT: state_nxt = FETCH;
        default:  state_nxt = IDLE;
      endcase
    end
  end

`ifdef FETCH_CTRL_STATS_EN
  logic stall_cyc;

  assign stall_cyc = (state == HOLD) || (state == WAIT_MISS) ||
                     ((state == FETCH) && ibuf_full_i);

  // Saturating stall-cycle counter; only reset clears it, flush does not.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_o <= 32'h0000_0000;
    end else if (stall_cyc && (stall_cnt_o != 32'hFFFF_FFFF)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/ibuf_fetch_ctrl.md
IBUF_FETCH_CTRL -- requirements
Module: ibuf_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, the fetch address loaded at reset.
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, the reset: asynchronous, active-low.
REQ-004 SHALL have port flush_rt_i, input, 1, retire-stage flush/redirect request.
REQ-005 SHALL have port redirect_pc_i, input, 64, the redirect target, sampled when flush_rt_i=1.
REQ-006 SHALL have port ibuf_full_i, input, 1, the instruction buffer full flag (the buffer cannot accept 8 more instructions).
REQ-007 SHALL have port ic_ack_i, input, 1, an icache hit: the line for fetch_pc_o is returned this cycle.
REQ-008 SHALL have port ic_miss_i, input, 1, an icache miss for fetch_pc_o this cycle.
REQ-009 SHALL have port ic_fill_i, input, 1, the outstanding miss refill is complete.
REQ-010 SHALL have port fetch_req_o, output, 1, the fetch request to the icache.
REQ-011 SHALL have port fetch_pc_o, output, 64, the current fetch address; bits [1:0] are always 0.
REQ-012 SHALL have port inst_vld_o, output, 8, per-slot valid mask for the 8-instruction line sent to the buffer.
REQ-013 SHALL have port stall_cnt_o, output, 32, the stall-cycle counter; this port exists only with FETCH_CTRL_STATS_EN.

Function
REQ-014 SHALL implement the states IDLE, FETCH, HOLD, WAIT_MISS and REDIRECT in a registered state machine.
REQ-015 SHALL go IDLE->FETCH unconditionally on the first clock after reset deasserts.
REQ-016 SHALL drive fetch_req_o = (state==FETCH) && !ibuf_full_i, combinationally; it is 0 in all other states.
REQ-017 SHALL, in FETCH with fetch_req_o=1 and ic_ack_i=1, drive inst_vld_o[k]=1 for every k >= fetch_pc_o[4:2] and 0 otherwise; in all other cases inst_vld_o=8'h00.
REQ-018 SHALL, on an accepted ack, load fetch_pc_o with {fetch_pc_o[63:5]+1, 5'b0} on the next edge; the increment wraps modulo 2^64.
REQ-019 SHALL move FETCH->WAIT_MISS on ic_miss_i while fetch_req_o=1, holding fetch_pc_o; if ic_ack_i is also 1 that cycle, the miss wins and the ack is ignored.
REQ-020 SHALL move WAIT_MISS->FETCH on ic_fill_i, with fetch_pc_o unchanged, so the same line is re-requested.
REQ-021 SHALL move FETCH->HOLD when ibuf_full_i=1, and HOLD->FETCH on the first cycle with ibuf_full_i=0.
REQ-022 SHALL, on flush_rt_i=1 in any state, load fetch_pc_o with {redirect_pc_i[63:2],2'b00} and enter REDIRECT; flush has priority over ack, miss, fill and full in the same cycle.
REQ-023 SHALL drive fetch_req_o=0 and inst_vld_o=0 for exactly one cycle in REDIRECT, then enter FETCH; a second flush during REDIRECT reloads the PC and stays in REDIRECT one more cycle.
REQ-024 SHALL ignore ic_ack_i, ic_miss_i and ic_fill_i in states where they are not listed above.

Reset
REQ-025 SHALL, while reset_n=0, asynchronously force state=IDLE, fetch_pc_o={RESET_PC[63:2],2'b00}, fetch_req_o=0, inst_vld_o=0 and stall_cnt_o=0.
REQ-026 SHALL, if reset asserts mid-miss or mid-hold, discard the pending operation; no request is reissued until FETCH is re-entered.

Configuration
REQ-027 SHALL, with FETCH_CTRL_STATS_EN defined, count cycles in HOLD or WAIT_MISS, plus FETCH cycles with ibuf_full_i=1, in stall_cnt_o; the counter saturates at 32'hFFFFFFFF and is not cleared by flush.
REQ-028 SHALL, without FETCH_CTRL_STATS_EN, omit stall_cnt_o and the counter logic entirely; all other behaviour is identical.

Verification
REQ-029 SHALL cover: RESET_PC=64'h1000, release reset, ic_ack_i=1 every cycle -> fetch_pc_o = 1000, 1020, 1040 on consecutive FETCH cycles, inst_vld_o=8'hFF each cycle.
REQ-030 SHALL cover: flush with redirect_pc_i=64'h200C -> one REDIRECT cycle with fetch_req_o=0, then fetch_pc_o=200C, and on ack inst_vld_o=8'b11111000, next fetch_pc_o=2020.
REQ-031 SHALL cover: ic_miss_i=1 together with ic_ack_i=1 -> WAIT_MISS, inst_vld_o=0, fetch_pc_o held; ic_fill_i 5 cycles later -> same PC re-requested.
REQ-032 SHALL cover: ibuf_full_i=1 for 3 cycles -> fetch_req_o=0 throughout, and with FETCH_CTRL_STATS_EN stall_cnt_o advances by 4 (entry cycle + 3 HOLD cycles per REQ-027); resume on release.
REQ-033 SHALL cover: flush_rt_i in the same cycle as ic_fill_i while in WAIT_MISS -> REDIRECT taken, fetch_pc_o = redirect target.
REQ-034 SHALL cover: fetch_pc_o=64'hFFFFFFFFFFFFFFE0 with ack -> wraps to 64'h0; asynchronous reset mid-WAIT_MISS -> IDLE and RESET_PC immediately.
